// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: iterative AES-128 round controller.
// Performs the initial AddRoundKey, then walks a shared registered round
// datapath through NR passes, fetching round keys by index.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   key_ready           key schedule complete
//   in_valid/in_ready   plaintext handshake, in_data plaintext
//   out_valid/out_ready ciphertext handshake, out_data ciphertext
//   rk_idx/rk_data      round-key index (registered) and returned key
//   rnd_*               issue/result interface to the round datapath
//   busy, round_cnt     status: not idle, current round number
//   err                 sticky timeout flag
module aes_round_sequencer #(
    parameter int DATA_W    = 128,
    parameter int NR        = 10,
    parameter int ROUND_LAT = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_ready,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [3:0]        rk_idx,
    input  logic [DATA_W-1:0] rk_data,
    output logic              rnd_valid_out,
    output logic              rnd_key_valid,
    output logic [DATA_W-1:0] rnd_data,
    output logic [DATA_W-1:0] rnd_key,
    output logic              rnd_last,
    input  logic              rnd_valid_in,
    input  logic [DATA_W-1:0] rnd_data_in,
    output logic              busy,
    output logic [3:0]        round_cnt,
    output logic              err
);

    localparam int WCW = $clog2(TIMEOUT + 1);
    localparam logic [3:0] NR4 = 4'(NR);
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        round_nxt;
    logic [3:0]        rk_idx_nxt;
    logic [DATA_W-1:0] state_reg;
    logic [DATA_W-1:0] state_reg_nxt;
    logic [WCW-1:0]    wait_cnt;
    logic [WCW-1:0]    wait_cnt_nxt;
    logic              err_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            round_cnt <= '0;
            rk_idx    <= '0;
            state_reg <= '0;
            wait_cnt  <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            round_cnt <= round_nxt;
            rk_idx    <= rk_idx_nxt;
            state_reg <= state_reg_nxt;
            wait_cnt  <= wait_cnt_nxt;
            err       <= err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        round_nxt     = round_cnt;
        rk_idx_nxt    = rk_idx;
        state_reg_nxt = state_reg;
        wait_cnt_nxt  = wait_cnt;
        err_nxt       = err;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        out_data      = '0;
        rnd_valid_out = 1'b0;
        rnd_key_valid = 1'b0;
        rnd_data      = '0;
        rnd_last      = 1'b0;

        unique case (state)
            IDLE: begin
                in_ready   = key_ready;
                rk_idx_nxt = '0;
                // rk_idx is already 0 here, so rk_data is the whitening key.
                if (in_valid && key_ready) begin
                    state_reg_nxt = in_data ^ rk_data;
                    round_nxt     = 4'd1;
                    rk_idx_nxt    = 4'd1;
                    err_nxt       = 1'b0;
                    state_nxt     = ISSUE;
                end
            end
            ISSUE: begin
                rnd_valid_out = 1'b1;
                rnd_key_valid = 1'b1;
                rnd_data      = state_reg;
                rnd_last      = (round_cnt == NR4);
                wait_cnt_nxt  = '0;
                state_nxt     = WAIT;
            end
            WAIT: begin
                rnd_key_valid = 1'b1;
                wait_cnt_nxt  = wait_cnt + 1'b1;
                if (rnd_valid_in) begin
                    state_reg_nxt = rnd_data_in;
                    if (round_cnt >= NR4) begin
                        state_nxt = DONE;
                    end else begin
                        round_nxt  = round_cnt + 4'd1;
                        rk_idx_nxt = round_cnt + 4'd1;
                        state_nxt  = ISSUE;
                    end
                end else if (wait_cnt == WAIT_MAX) begin
                    // Datapath never answered: drop the block.
                    err_nxt    = 1'b1;
                    round_nxt  = '0;
                    rk_idx_nxt = '0;
                    state_nxt  = IDLE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                out_data  = state_reg;
                if (out_ready) begin
                    round_nxt  = '0;
                    rk_idx_nxt = '0;
                    state_nxt  = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign rnd_key = rk_data;
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb_aes_round_sequencer: randomized self-checking bench with an AES-128
// reference model, a key-store model and a fixed-latency round datapath model.
module tb_aes_round_sequencer;

    localparam int DATA_W    = 128;
    localparam int NR        = 10;
    localparam int ROUND_LAT = 4;
    localparam int TIMEOUT   = 16;
    localparam int LAT       = 1 + NR * (ROUND_LAT + 1);

    logic              clk = 1'b0;
    logic              reset;
    logic              key_ready;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [3:0]        rk_idx;
    logic [DATA_W-1:0] rk_data;
    logic              rnd_valid_out;
    logic              rnd_key_valid;
    logic [DATA_W-1:0] rnd_data;
    logic [DATA_W-1:0] rnd_key;
    logic              rnd_last;
    logic              rnd_valid_in;
    logic [DATA_W-1:0] rnd_data_in;
    logic              busy;
    logic [3:0]        round_cnt;
    logic              err;

    aes_round_sequencer #(
        .DATA_W(DATA_W), .NR(NR),
        .ROUND_LAT(ROUND_LAT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .key_ready(key_ready),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .rk_idx(rk_idx), .rk_data(rk_data),
        .rnd_valid_out(rnd_valid_out), .rnd_key_valid(rnd_key_valid),
        .rnd_data(rnd_data), .rnd_key(rnd_key), .rnd_last(rnd_last),
        .rnd_valid_in(rnd_valid_in), .rnd_data_in(rnd_data_in),
        .busy(busy), .round_cnt(round_cnt), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else
            n_pass++;
    endtask

    // ---------------- AES reference ----------------
    logic [7:0] sb [256];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = xt(a);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] d = {b, b};
        return d[15-n -: 8];
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] s, p;
            s = 8'(x);
            p = 8'h01;
            for (int k = 1; k < 8; k++) begin
                s = gmul(s, s);
                p = gmul(p, s);
            end
            sb[x] = p ^ rotl(p, 1) ^ rotl(p, 2) ^ rotl(p, 3)
                    ^ rotl(p, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_round(input logic [127:0] s,
                                               input logic [127:0] k,
                                               input logic last);
        logic [7:0] a [16];
        logic [7:0] b [16];
        logic [7:0] x0, x1, x2, x3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) a[i] = sb[s[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                b[c*4+r] = a[((c + r) % 4) * 4 + r];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                x0 = b[c*4]; x1 = b[c*4+1];
                x2 = b[c*4+2]; x3 = b[c*4+3];
                b[c*4]   = xt(x0) ^ xt(x1) ^ x1 ^ x2 ^ x3;
                b[c*4+1] = x0 ^ xt(x1) ^ xt(x2) ^ x2 ^ x3;
                b[c*4+2] = x0 ^ x1 ^ xt(x2) ^ xt(x3) ^ x3;
                b[c*4+3] = xt(x0) ^ x0 ^ x1 ^ x2 ^ xt(x3);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
        return o ^ k;
    endfunction

    function automatic logic [127:0] rkey(input logic [127:0] key,
                                          input int r);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]}
                    ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt,
                                             input logic [127:0] key);
        logic [127:0] s = pt ^ rkey(key, 0);
        for (int r = 1; r <= NR; r++)
            s = aes_round(s, rkey(key, r), r == NR);
        return s;
    endfunction

    // ---------------- key store and datapath models ----------------
    logic [127:0] rk_tab [16];
    logic [127:0] cur_key;
    assign rk_data = rk_tab[rk_idx];

    task automatic set_key(input logic [127:0] key);
        cur_key = key;
        for (int r = 0; r < 16; r++)
            rk_tab[r] = (r <= NR) ? rkey(key, r) : '0;
    endtask

    logic         drop;
    logic         spur;
    logic         pv [ROUND_LAT];
    logic [127:0] pd [ROUND_LAT];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ROUND_LAT; i++) pv[i] <= 1'b0;
        end else begin
            pv[0] <= rnd_valid_out && rnd_key_valid && !drop;
            pd[0] <= aes_round(rnd_data, rnd_key, rnd_last);
            for (int i = 1; i < ROUND_LAT; i++) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end

    assign rnd_valid_in = pv[ROUND_LAT-1] | spur;
    assign rnd_data_in  = spur ? 128'hdead_beef_0bad_f00d_1234_5678_9abc_def0
                               : pd[ROUND_LAT-1];

    // ---------------- stimulus ----------------
    int t_acc;

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic start(input logic [127:0] pt);
        logic ok = 1'b0;
        in_valid = 1'b1;
        in_data  = pt;
        for (int k = 0; k < 100; k++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("accept", ok, 1);
        t_acc = cyc;
        chk("rk_idx_idle", rk_idx, 0);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = rnd128();
        chk("err_clear", err, 0);
        chk("busy_run", busy, 1);
    endtask

    task automatic run_block(input logic [127:0] pt, input logic [127:0] ct,
                             input int hold);
        int n = 1;
        int issues = 0;
        out_ready = (hold == 0);
        start(pt);
        while (1) begin
            if (n == 3) begin
                chk("wait_in_ready", in_ready, 0);
                in_valid = 1'b1;
                in_data  = ~pt;
            end
            if (n == 4) in_valid = 1'b0;
            if (n == 10) key_ready = 1'b0;
            if (n == 30) key_ready = 1'b1;
            if (rnd_valid_out) begin
                issues++;
                chk("rk_idx_issue", rk_idx, issues);
                chk("rnd_last", rnd_last, issues == NR);
            end
            if (out_valid || n >= 200) break;
            @(negedge clk);
            n++;
        end
        key_ready = 1'b1;
        chk("latency", n, LAT);
        chk("issues", issues, NR);
        chk("ciphertext", out_data, ct);
        for (int h = 0; h < hold; h++) begin
            spur = (h == 5);
            @(negedge clk);
            spur = 1'b0;
            chk("hold_data", out_data, ct);
            chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_out_valid", out_valid, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_rnd_valid"}, rnd_valid_out, 0);
        chk({tag, "_key_valid"}, rnd_key_valid, 0);
        chk({tag, "_rnd_last"}, rnd_last, 0);
        chk({tag, "_round_cnt"}, round_cnt, 0);
        chk({tag, "_rk_idx"}, rk_idx, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    initial begin
        logic [127:0] pt, key;
        logic         seen;
        int           n, t_prev;

        build_sbox();
        reset     = 1'b1;
        key_ready = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        spur      = 1'b0;
        drop      = 1'b0;
        set_key(128'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_zero("reset");

        // no accept without key_ready
        in_valid = 1'b1;
        in_data  = rnd128();
        repeat (4) begin
            @(negedge clk);
            chk("nokey_in_ready", in_ready, 0);
            chk("nokey_busy", busy, 0);
        end
        in_valid = 1'b0;

        // FIPS-197 C.1
        key = 128'h000102030405060708090a0b0c0d0e0f;
        pt  = 128'h00112233445566778899aabbccddeeff;
        chk("ref_model", aes_enc(pt, key),
            128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        set_key(key);
        key_ready = 1'b1;
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        @(negedge clk);
        chk("spur_idle_busy", busy, 0);
        chk("spur_idle_rcnt", round_cnt, 0);
        run_block(pt, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 20);
        pt = rnd128();
        run_block(pt, aes_enc(pt, cur_key), 0);

        // timeout
        drop = 1'b1;
        start(rnd128());
        n = 1;
        seen = 1'b0;
        while (!err && n < 100) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
            n++;
        end
        drop = 1'b0;
        chk("to_err", err, 1);
        chk("to_cycles", n, 2 + TIMEOUT);
        chk("to_busy", busy, 0);
        chk("to_round_cnt", round_cnt, 0);
        chk("to_rk_idx", rk_idx, 0);
        chk("to_no_out", seen, 0);
        repeat (3) @(negedge clk);
        chk("to_err_sticky", err, 1);
        pt = rnd128();
        run_block(pt, aes_enc(pt, cur_key), 0);

        // reset in round 5 WAIT
        start(rnd128());
        for (n = 2; n <= 23; n++) @(negedge clk);
        chk("mid_round_cnt", round_cnt, 5);
        chk("mid_wait", rnd_valid_out, 0);
        reset = 1'b1;
        @(negedge clk);
        chk_zero("mid_reset");
        reset = 1'b0;
        @(negedge clk);
        pt = rnd128();
        run_block(pt, aes_enc(pt, cur_key), 0);

        // back-to-back, fresh random key
        key_ready = 1'b0;
        set_key(rnd128());
        @(negedge clk);
        key_ready = 1'b1;
        t_prev = 0;
        for (int i = 0; i < 4; i++) begin
            pt = rnd128();
            run_block(pt, aes_enc(pt, cur_key), 0);
            if (i > 0) chk("spacing", t_acc - t_prev, LAT + 1);
            t_prev = t_acc;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
- Iterative controller that drives one shared registered AES round datapath (SubBytes→ShiftRows→MixColumns→AddRoundKey) through all NR rounds of an AES-128 encryption.
- Accepts a plaintext block, performs the initial AddRoundKey, then issues NR passes through the datapath, fetching round keys by index from the key store.
- Asserts `rnd_last` on the final pass (datapath bypasses MixColumns) and returns ciphertext on a valid/ready output.
- Sits between the SoC-facing AES wrapper and the round datapath/key store.

Parameters:
- DATA_W, 128, block and round-key width.
- NR, 10, number of rounds.
- ROUND_LAT, 4, datapath latency in cycles from `rnd_valid_out` to `rnd_valid_in`.
- TIMEOUT, 16, maximum cycles in WAIT before error abort; must be greater than ROUND_LAT.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset, shared with the round datapath
- key_ready  in  1  key schedule complete; round keys valid
- in_valid  in  1  plaintext valid
- in_ready  out  1  sequencer can accept a block
- in_data  in  DATA_W  plaintext
- out_valid  out  1  ciphertext valid
- out_ready  in  1  consumer accepts ciphertext
- out_data  out  DATA_W  ciphertext
- rk_idx  out  4  round-key index to key store (registered)
- rk_data  in  DATA_W  round key for rk_idx; combinational from key store, stable while rk_idx is stable
- rnd_valid_out  out  1  issue pulse to datapath
- rnd_key_valid  out  1  round key valid to datapath
- rnd_data  out  DATA_W  state to datapath
- rnd_key  out  DATA_W  round key to datapath (= rk_data)
- rnd_last  out  1  final round; datapath skips MixColumns
- rnd_valid_in  in  1  datapath result valid
- rnd_data_in  in  DATA_W  datapath result
- busy  out  1  high in any state other than IDLE
- round_cnt  out  4  current round number
- err  out  1  sticky timeout flag

Behaviour:
- Reset (synchronous, highest priority): state=IDLE; round_cnt=0; rk_idx=0; state_reg=0; wait counter=0; err=0. All valid outputs, `busy` and `rnd_last` are 0; `out_data`=0.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - rk_idx=0; in_ready=key_ready.
  - On in_valid&&in_ready: state_reg<=in_data^rk_data; round_cnt<=1; rk_idx<=1; err<=0; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - rnd_valid_out=1; rnd_data=state_reg; rnd_last=(round_cnt==NR).
  - Clear the wait counter; go to WAIT.
- ISSUE and WAIT: rnd_key_valid=1; rnd_key=rk_data; rk_idx=round_cnt, held constant.
- WAIT:
  - The wait counter increments each cycle.
  - On rnd_valid_in: state_reg<=rnd_data_in.
    - If round_cnt==NR, go to DONE.
    - Otherwise round_cnt++, rk_idx++, go to ISSUE.
  - If the counter reaches TIMEOUT without rnd_valid_in: err<=1; go to IDLE; round_cnt<=0; rk_idx<=0; block discarded, no out_valid.
- DONE:
  - out_valid=1; out_data=state_reg. Both held stable until out_ready.
  - On out_valid&&out_ready: go to IDLE; round_cnt<=0; rk_idx<=0.
  - in_ready=0 throughout DONE; no overlap of blocks.
- Latency: accept at cycle T → out_valid at T+1+NR*(ROUND_LAT+1). With defaults this is T+51. Each round costs ROUND_LAT+1 cycles.
- rnd_valid_in outside WAIT (stale or spurious): ignored, no state change.
- in_valid while busy: not accepted (in_ready=0); the sender must hold its data.
- key_ready low in IDLE: no accept. key_ready dropping mid-block: ignored; the block completes.
- Reset mid-block: immediate return to IDLE. The datapath is cleared by the same reset, so no stale result returns.
- `err` remains set until the next accepted block or reset.
- round_cnt saturates at NR; it never wraps.

Test Plan:
- FIPS-197 C.1: key 000102…0f loaded, key_ready=1, in_data 00112233445566778899aabbccddeeff → out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 51 cycles after accept. Check rnd_last=1 only on the round-10 issue and rk_idx sequence 0,1..10.
- Back-pressure: hold out_ready=0 for 20 cycles after out_valid → out_data stable, in_ready=0. Raise out_ready → IDLE next cycle; a second block is accepted immediately and is correct.
- Timeout: datapath model never returns rnd_valid_in → err=1 after TIMEOUT(16) WAIT cycles, state IDLE, no out_valid, busy=0. Next accepted block clears err and completes correctly.
- Reset mid-operation: assert reset during round 5 WAIT → next cycle all outputs 0, round_cnt=0. After reset release, a fresh block yields the correct ciphertext at 51 cycles.
- Spurious/blocked input: pulse rnd_valid_in in IDLE and DONE → no state change. Assert in_valid with key_ready=0 → in_ready=0, no accept. Assert in_valid during WAIT → not accepted.
- Back-to-back: 4 random plaintexts with out_ready=1 → ciphertexts match reference model, spacing 52 cycles between accepts.
